mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between y86cpu's instruction-fetch port and data port.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter_fetch_line_buf.sv | 42 ++++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: default widths, FSM states and beat-count helper
// shared by the unified-memory arbiter and its interface.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int INST_W_DEF = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_e;

  // bus words needed to cover one instruction
  function automatic int ceil_div(int num, int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU fetch/data ports plus memory bus of the arbiter.
// master = arbiter side, slave = CPU/memory environment side.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int INST_W = INST_W_DEF
);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_valid_o;
  logic [INST_W-1:0] if_inst_o;
  logic              dm_read_i;
  logic              dm_write_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_valid_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              stall_o;
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_ack_i;
  logic [DATA_W-1:0] bus_rdata_i;

  modport master (
    input  if_req_i, if_addr_i,
    input  dm_read_i, dm_write_i,
    input  dm_addr_i, dm_wdata_i,
    input  bus_ack_i, bus_rdata_i,
    output if_valid_o, if_inst_o,
    output dm_valid_o, dm_rdata_o,
    output stall_o,
    output bus_req_o, bus_we_o,
    output bus_addr_o, bus_wdata_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    output dm_read_i, dm_write_i,
    output dm_addr_i, dm_wdata_i,
    output bus_ack_i, bus_rdata_i,
    input  if_valid_o, if_inst_o,
    input  dm_valid_o, dm_rdata_o,
    input  stall_o,
    input  bus_req_o, bus_we_o,
    input  bus_addr_o, bus_wdata_o
  );

endinterface

// File: rtl/mem_arbiter_fetch_line_buf.sv
// mem_arbiter_fetch_line_buf: one-entry {vld, addr, inst} copy of the
// last fetched instruction; compiled only with MEM_ARB_FETCH_BUF_EN.
`ifdef MEM_ARB_FETCH_BUF_EN
module mem_arbiter_fetch_line_buf #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [INST_W-1:0] load_inst,
  input  logic              clear,
  input  logic [ADDR_W-1:0] look_addr,
  output logic              hit,
  output logic [INST_W-1:0] hit_inst
);

  logic              vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic [INST_W-1:0] inst_q;

  // writes invalidate; each completed fetch refills the entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      inst_q <= '0;
    end else if (clear) begin
      vld_q <= 1'b0;
    end else if (load) begin
      vld_q  <= 1'b1;
      addr_q <= load_addr;
      inst_q <= load_inst;
    end
  end

  assign hit      = vld_q & (addr_q == look_addr);
  assign hit_inst = inst_q;

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data,
// data first; MEM_ARB_FETCH_BUF_EN adds a 1-entry fetch buffer.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master io
);

  localparam int FETCH_BEATS = ceil_div(INST_W, DATA_W);
  localparam int BEAT_BYTES  = DATA_W / 8;
  localparam int CNT_W =
    (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT =
    CNT_W'(FETCH_BEATS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic              if_done_q, dm_done_q;
  logic              if_valid_q, dm_valid_q;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] rdata_q;

  logic              dm_pend, if_pend;
  logic              dm_go, if_go, stall;
  logic              data_ack, fetch_ack, fetch_last;
  logic              hit_take;
  logic              buf_hit;
  logic [INST_W-1:0] buf_inst;

  logic              bus_req, bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;

  assign dm_pend = (io.dm_read_i | io.dm_write_i) & ~dm_done_q;
  assign if_pend = io.if_req_i & ~if_done_q;
  assign stall   = ~rst & (dm_pend | if_pend);

  // a request whose valid pulse is out this cycle is already served
  assign dm_go = dm_pend & ~dm_valid_q;
  assign if_go = if_pend & ~if_valid_q;

  assign data_ack   = (state_q == DATA) & io.bus_ack_i;
  assign fetch_ack  = (state_q == FETCH) & io.bus_ack_i;
  assign fetch_last = fetch_ack & (beat_cnt_q == LAST_BEAT);
  assign hit_take   = (state_q == IDLE) & ~dm_go
                    & if_go & buf_hit;

`ifdef MEM_ARB_FETCH_BUF_EN
  mem_arbiter_fetch_line_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_fetch_line_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (fetch_last),
    .load_addr (io.if_addr_i),
    .load_inst (inst_d),
    .clear     (data_ack & bus_we),
    .look_addr (io.if_addr_i),
    .hit       (buf_hit),
    .hit_inst  (buf_inst)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_inst = '0;
`endif

  // next state and bus beat drive; beat fields are pure functions of
  // state and held requests, so they stay stable until ack
  always_comb begin
    state_d   = state_q;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (dm_go)
          state_d = DATA;
        else if (if_go & ~buf_hit)
          state_d = FETCH;
      end
      DATA: begin
        bus_req  = 1'b1;
        bus_we   = io.dm_write_i;
        bus_addr = io.dm_addr_i;
        if (io.dm_write_i)
          bus_wdata = io.dm_wdata_i;
        if (io.bus_ack_i)
          state_d = IDLE;
      end
      FETCH: begin
        bus_req  = 1'b1;
        bus_addr = io.if_addr_i
                 + ADDR_W'(beat_cnt_q) * ADDR_W'(BEAT_BYTES);
        if (fetch_last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // drop the current beat into its little-endian slot
  always_comb begin
    inst_d = inst_q;
    for (int b = 0; b < INST_W; b++)
      if (b / DATA_W == int'(beat_cnt_q))
        inst_d[b] = io.bus_rdata_i[b % DATA_W];
  end

  // FSM, beat counter, assembly and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      inst_q     <= '0;
      rdata_q    <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fetch_last)
        beat_cnt_q <= '0;
      else if (fetch_ack)
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      if (fetch_ack)
        inst_q <= inst_d;
      else if (hit_take)
        inst_q <= buf_inst;
      if (data_ack)
        rdata_q <= bus_we ? '0 : io.bus_rdata_i;
      if_valid_q <= fetch_last | hit_take;
      dm_valid_q <= data_ack;
    end
  end

  // per-step completion flags, cleared when the pipeline advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
    end else if (!stall) begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
    end else begin
      if (if_valid_q)
        if_done_q <= 1'b1;
      if (dm_valid_q)
        dm_done_q <= 1'b1;
    end
  end

  assign io.stall_o     = stall;
  assign io.if_valid_o  = if_valid_q;
  assign io.if_inst_o   = inst_q;
  assign io.dm_valid_o  = dm_valid_q;
  assign io.dm_rdata_o  = rdata_q;
  assign io.bus_req_o   = bus_req;
  assign io.bus_we_o    = bus_we;
  assign io.bus_addr_o  = bus_addr;
  assign io.bus_wdata_o = bus_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + random steps; a memory-level reference model
// fills expectation queues that a negedge monitor pops and compares.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arbiter_if io ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_dm[$];
  logic [47:0] exp_if[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0, rel_cyc = 0;
  int last_if_cyc = 0, last_dm_cyc = 0, last_ack_cyc = 0;
  int ack_delay = 0, wcnt = 0;
  int hold_len = 0, last_hold = 0, beat_total = 0;
  bit in_beat = 1'b0, stable_bad = 1'b0;
  beat_t       held;
  logic [31:0] last_beat_addr = '0;
  logic [47:0] last_inst = '0;
`ifdef MEM_ARB_FETCH_BUF_EN
  bit          ref_bv = 1'b0;
  logic [31:0] ref_ba = '0;
`endif

  function automatic logic [31:0] dflt(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] bus_rd(logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return dflt(a);
  endfunction

  // instruction = two little-endian words, top 16 bits dropped
  function automatic logic [47:0] ref_inst(logic [31:0] a);
    logic [63:0] w;
    w = {ref_rd(a + 32'd4), ref_rd(a)};
    return w[47:0];
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // cycle counter
  always @(posedge clk) cyc++;

  // memory responder: ack after ack_delay wait cycles per beat
  always @(posedge clk) begin
    #2;
    if (rst || !io.bus_req_o) begin
      io.bus_ack_i = 1'b0;
      wcnt = 0;
    end else if (wcnt >= ack_delay) begin
      io.bus_ack_i   = 1'b1;
      io.bus_rdata_i = bus_rd(io.bus_addr_o);
      wcnt = 0;
    end else begin
      io.bus_ack_i   = 1'b0;
      io.bus_rdata_i = $urandom;
      wcnt++;
    end
  end

  // monitor: beat stability, beat order and result pulses
  always @(negedge clk) begin
    beat_t cur, e;
    if (rst) begin
      in_beat = 1'b0;
    end else begin
      if (io.bus_req_o) begin
        cur.we    = io.bus_we_o;
        cur.addr  = io.bus_addr_o;
        cur.wdata = io.bus_wdata_o;
        if (!in_beat) begin
          held = cur;
          hold_len = 0;
          stable_bad = 1'b0;
        end else if (cur !== held) begin
          stable_bad = 1'b1;
        end
        in_beat = 1'b1;
        hold_len++;
        if (io.bus_ack_i) begin
          chk("beat_stable", 64'(stable_bad), 64'd0);
          if (exp_beats.size() == 0) begin
            bad("beat_unexpected");
          end else begin
            e = exp_beats.pop_front();
            chk("beat_we", 64'(cur.we), 64'(e.we));
            chk("beat_addr", 64'(cur.addr), 64'(e.addr));
            if (e.we)
              chk("beat_wdata", 64'(cur.wdata), 64'(e.wdata));
          end
          if (cur.we) bus_mem[cur.addr] = cur.wdata;
          last_hold = hold_len;
          last_ack_cyc = cyc;
          last_beat_addr = cur.addr;
          beat_total++;
          in_beat = 1'b0;
        end
      end else if (in_beat) begin
        chk("req_held", 64'(io.bus_req_o), 64'd1);
        in_beat = 1'b0;
      end
      if (io.dm_valid_o) begin
        last_dm_cyc = cyc;
        if (exp_dm.size() == 0)
          bad("dm_valid_unexpected");
        else
          chk("dm_rdata", 64'(io.dm_rdata_o),
              64'(exp_dm.pop_front()));
      end
      if (io.if_valid_o) begin
        last_if_cyc = cyc;
        last_inst = io.if_inst_o;
        if (exp_if.size() == 0)
          bad("if_valid_unexpected");
        else
          chk("if_inst", 64'(io.if_inst_o),
              64'(exp_if.pop_front()));
      end
    end
  end

  // model a step (data before fetch), queue its effects, drive it
  task automatic issue(bit fe, bit rd, bit wr, logic [31:0] fa,
                       logic [31:0] da, logic [31:0] wd);
    beat_t b;
    bit hit;
    if (rd || wr) begin
      b.we = wr;
      b.addr = da;
      b.wdata = wr ? wd : 32'h0;
      exp_beats.push_back(b);
      if (wr) begin
        ref_mem[da] = wd;
        exp_dm.push_back(32'h0);
`ifdef MEM_ARB_FETCH_BUF_EN
        ref_bv = 1'b0;
`endif
      end else begin
        exp_dm.push_back(ref_rd(da));
      end
    end
    if (fe) begin
      hit = 1'b0;
`ifdef MEM_ARB_FETCH_BUF_EN
      hit = ref_bv && (ref_ba == fa);
      ref_bv = 1'b1;
      ref_ba = fa;
`endif
      if (!hit) begin
        for (int k = 0; k < 2; k++) begin
          b.we = 1'b0;
          b.addr = fa + 32'(k * 4);
          b.wdata = 32'h0;
          exp_beats.push_back(b);
        end
      end
      exp_if.push_back(ref_inst(fa));
    end
    io.if_req_i   = fe;
    io.if_addr_i  = fa;
    io.dm_read_i  = rd;
    io.dm_write_i = wr;
    io.dm_addr_i  = da;
    io.dm_wdata_i = wd;
    start_cyc = cyc;
  endtask

  task automatic wait_release(bit any);
    int n;
    n = 0;
    @(negedge clk);
    chk("stall_rise", 64'(io.stall_o), 64'(any));
    while (io.stall_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (io.stall_o) bad("step_timeout");
    rel_cyc = cyc;
    chk("drain", 64'(exp_beats.size() + exp_dm.size()
        + exp_if.size()), 64'd0);
    exp_beats.delete();
    exp_dm.delete();
    exp_if.delete();
  endtask

  task automatic step(bit fe, bit rd, bit wr, logic [31:0] fa,
                      logic [31:0] da, logic [31:0] wd);
    @(posedge clk);
    #1;
    issue(fe, rd, wr, fa, da, wd);
    wait_release(fe | rd | wr);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      io.if_req_i   = 1'b0;
      io.dm_read_i  = 1'b0;
      io.dm_write_i = 1'b0;
      @(negedge clk);
      chk("idle_stall", 64'(io.stall_o), 64'd0);
      chk("idle_req", 64'(io.bus_req_o), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b0;
    bit fe, rd, wr;
    logic [31:0] fa, da, wd;
    io.if_req_i    = 1'b1;
    io.if_addr_i   = '0;
    io.dm_read_i   = 1'b1;
    io.dm_write_i  = 1'b0;
    io.dm_addr_i   = '0;
    io.dm_wdata_i  = '0;
    io.bus_ack_i   = 1'b0;
    io.bus_rdata_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(io.stall_o), 64'd0);
    chk("rst_bus_req", 64'(io.bus_req_o), 64'd0);
    chk("rst_bus_we", 64'(io.bus_we_o), 64'd0);
    chk("rst_bus_addr", 64'(io.bus_addr_o), 64'd0);
    chk("rst_if_valid", 64'(io.if_valid_o), 64'd0);
    chk("rst_if_inst", 64'(io.if_inst_o), 64'd0);
    chk("rst_dm_valid", 64'(io.dm_valid_o), 64'd0);
    chk("rst_dm_rdata", 64'(io.dm_rdata_o), 64'd0);
    io.if_req_i  = 1'b0;
    io.dm_read_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // fetch at 0x100 with zero-wait acks
    ref_mem[32'h100] = 32'h33221100;
    bus_mem[32'h100] = 32'h33221100;
    ref_mem[32'h104] = 32'h77665544;
    bus_mem[32'h104] = 32'h77665544;
    step(1, 0, 0, 32'h100, 0, 0);
    chk("t1_inst", 64'(last_inst), 64'h554433221100);
    chk("t1_lat", 64'(last_if_cyc - start_cyc), 64'd3);
    chk("t1_release", 64'(rel_cyc - last_if_cyc), 64'd1);

`ifdef MEM_ARB_FETCH_BUF_EN
    b0 = beat_total;
    step(1, 0, 0, 32'h100, 0, 0);
    chk("t6_hit_beats", 64'(beat_total - b0), 64'd0);
    chk("t6_hit_lat", 64'(last_if_cyc - start_cyc), 64'd1);
    step(0, 0, 1, 0, 32'h900, 32'h12345678);
    b0 = beat_total;
    step(1, 0, 0, 32'h100, 0, 0);
    chk("t6_miss_beats", 64'(beat_total - b0), 64'd2);
`endif

    // simultaneous fetch and read: data goes first
    step(1, 1, 0, 32'h20, 32'h400, 0);
    chk("t2_dm_lat", 64'(last_dm_cyc - start_cyc), 64'd2);
    chk("t2_release", 64'(rel_cyc - start_cyc), 64'd6);

    // slow write: beat held 4 cycles
    ack_delay = 3;
    step(0, 0, 1, 0, 32'h80, 32'hDEADBEEF);
    chk("t3_hold", 64'(last_hold), 64'd4);
    chk("t3_valid_lat", 64'(last_dm_cyc - last_ack_cyc), 64'd1);
    ack_delay = 0;

    // fetch wraps past the top of the address space
    step(1, 0, 0, 32'hFFFFFFFC, 0, 0);
    chk("t4_wrap_addr", 64'(last_beat_addr), 64'd0);

    // reset while the second fetch beat waits for ack
    ack_delay = 2;
    @(posedge clk);
    #1;
    issue(1, 0, 0, 32'h200, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(io.bus_req_o && io.bus_addr_o == 32'h204)
               && n < 50);
    chk("t5_second_beat", 64'(io.bus_addr_o), 64'h204);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_req", 64'(io.bus_req_o), 64'd0);
    chk("t5_rst_if_valid", 64'(io.if_valid_o), 64'd0);
    chk("t5_rst_stall", 64'(io.stall_o), 64'd0);
    exp_beats.delete();
    exp_dm.delete();
    exp_if.delete();
    in_beat = 1'b0;
`ifdef MEM_ARB_FETCH_BUF_EN
    ref_bv = 1'b0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1, 0, 0, 32'h200, 0, 0);
    wait_release(1'b1);
    ack_delay = 0;
    idle(1);

    // random steps over a small shared address window
    for (int s = 0; s < 60; s++) begin
      n = $urandom_range(0, 7);
      fe = n[0];
      rd = n[1];
      wr = n[2];
      fa = 32'h400 + 32'($urandom_range(0, 15)) * 32'd4;
      da = 32'h400 + 32'($urandom_range(0, 15)) * 32'd4;
      wd = $urandom;
      ack_delay = $urandom_range(0, 3);
      step(fe, rd, wr, fa, da, wd);
      idle($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
